// File: rtl/llc_arb_pkg.sv
// +----------------------------------------------------------------------+
// | llc_arb_pkg: shared constants, width helpers and channel index type   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package llc_arb_pkg;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  localparam int NCH_MAX  = 8;
  localparam int CH_W_MAX = 3;

  typedef logic [CH_W_MAX-1:0] chan_idx_t;

  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // (base + k) mod n for base < n and k <= n
  function automatic int wrap_inc(input int base, input int k, input int n);
    int s;
    s = base + k;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/llc_req_arb_if.sv
// +----------------------------------------------------------------------+
// | llc_req_arb_if: request-side and grant-side bus of the LLC arbiter    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface llc_req_arb_if
  import llc_arb_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 128
) ();

  localparam int CH_W  = ch_w(NCH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [NCH-1:0]        in_valid;
  logic [NCH*DATA_W-1:0] in_data;
  logic [NCH-1:0]        in_ready;
  logic                  out_valid;
  logic [DATA_W-1:0]     out_data;
  logic [CH_W-1:0]       out_chan;
  logic                  out_ready;
  logic [NCH*CNT_W-1:0]  in_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan, in_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan, in_count
  );

endinterface

`default_nettype wire

// File: rtl/llc_chan_fifo.sv
// +----------------------------------------------------------------------+
// | llc_chan_fifo: flop-based per-channel request FIFO with occupancy     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module llc_chan_fifo
  import llc_arb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  output logic [DATA_W-1:0]       head_data,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    not_full,
  output logic                    not_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              do_push, do_pop;

  // Fullness is judged on the current count, so a full FIFO refuses a push
  // even when it is popped in the same cycle.
  assign do_push   = push & (count_q != FULL_CNT);
  assign do_pop    = pop & (count_q != '0);
  assign not_full  = (count_q != FULL_CNT);
  assign not_empty = (count_q != '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: rtl/llc_req_arb.sv
// +----------------------------------------------------------------------+
// | llc_req_arb: per-channel request FIFOs feeding a locked-grant arbiter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module llc_req_arb
  import llc_arb_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int DEPTH      = 4,
  parameter int DATA_W     = 128,
  parameter int PRIO_MODE  = 0,
  parameter int STARVE_LIM = 16
) (
  input  logic         clk,
  input  logic         rst,
  llc_req_arb_if.slave bus
);

  localparam int CH_W   = ch_w(NCH);
  localparam int CNT_W  = cnt_w(DEPTH);
  localparam int WAIT_W = $clog2(STARVE_LIM + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(STARVE_LIM);

  typedef logic [CH_W-1:0] ch_t;

  logic [NCH-1:0]       nonempty;
  logic [NCH-1:0]       fifo_ready;
  logic [NCH-1:0]       pop;
  logic [DATA_W-1:0]    head [NCH];
  logic [CNT_W-1:0]     count [NCH];
  logic [NCH*CNT_W-1:0] count_flat;

  logic                 lock_q, lock_d;
  chan_idx_t            lock_chan_q, lock_chan_d;
  ch_t                  rr_ptr_q, rr_ptr_d;
  logic [WAIT_W-1:0]    wait_cnt_q [NCH];
  logic [WAIT_W-1:0]    wait_cnt_d [NCH];

  chan_idx_t            rr_pick, fp_pick, st_pick, grant_idx;
  logic                 rr_found, fp_found, st_found;
  logic                 any_valid, handshake;
  logic [DATA_W-1:0]    head_sel;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    llc_chan_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.in_valid[i]),
      .push_data (bus.in_data[i*DATA_W +: DATA_W]),
      .pop       (pop[i]),
      .head_data (head[i]),
      .count     (count[i]),
      .not_full  (fifo_ready[i]),
      .not_empty (nonempty[i])
    );
  end

  // Candidate selection for both policies; a held lock overrides them.
  always_comb begin
    rr_pick  = '0;
    rr_found = 1'b0;
    fp_pick  = '0;
    fp_found = 1'b0;
    st_pick  = '0;
    st_found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!rr_found && nonempty[ch_t'(wrap_inc(int'(rr_ptr_q), k, NCH))]) begin
        rr_found = 1'b1;
        rr_pick  = chan_idx_t'(wrap_inc(int'(rr_ptr_q), k, NCH));
      end
      if (!fp_found && nonempty[ch_t'(k)]) begin
        fp_found = 1'b1;
        fp_pick  = chan_idx_t'(k);
      end
      if (!st_found && nonempty[ch_t'(k)] && (wait_cnt_q[ch_t'(k)] == WAIT_LIM)) begin
        st_found = 1'b1;
        st_pick  = chan_idx_t'(k);
      end
    end
    if (lock_q) begin
      grant_idx = lock_chan_q;
    end else if (PRIO_MODE == PRIO_FIXED) begin
      grant_idx = st_found ? st_pick : fp_pick;
    end else begin
      grant_idx = rr_pick;
    end
  end

  always_comb begin
    any_valid = (|nonempty) & ~rst;
    handshake = any_valid & bus.out_ready;
    head_sel  = '0;
    pop       = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_idx == chan_idx_t'(i)) begin
        head_sel     = head[ch_t'(i)];
        pop[ch_t'(i)] = handshake;
      end
    end

    // Lock whenever a grant is offered but not taken this cycle.
    lock_d      = any_valid & ~bus.out_ready;
    lock_chan_d = grant_idx;

    rr_ptr_d = rr_ptr_q;
    if (handshake) begin
      rr_ptr_d = ch_t'(wrap_inc(int'(grant_idx), 1, NCH));
    end

    for (int i = 0; i < NCH; i++) begin
      wait_cnt_d[ch_t'(i)] = wait_cnt_q[ch_t'(i)];
      if (PRIO_MODE != PRIO_FIXED || pop[ch_t'(i)]) begin
        wait_cnt_d[ch_t'(i)] = '0;
      end else if (nonempty[ch_t'(i)] && wait_cnt_q[ch_t'(i)] != WAIT_LIM) begin
        wait_cnt_d[ch_t'(i)] = wait_cnt_q[ch_t'(i)] + 1'b1;
      end
    end
  end

  always_comb begin
    count_flat = '0;
    for (int i = 0; i < NCH; i++) begin
      count_flat[i*CNT_W +: CNT_W] = rst ? '0 : count[ch_t'(i)];
    end
  end

  assign bus.out_valid = any_valid;
  assign bus.out_chan  = any_valid ? grant_idx[CH_W-1:0] : '0;
  assign bus.out_data  = head_sel;
  assign bus.in_ready  = fifo_ready | {NCH{rst}};
  assign bus.in_count  = count_flat;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q      <= 1'b0;
      lock_chan_q <= '0;
      rr_ptr_q    <= '0;
      for (int i = 0; i < NCH; i++) begin
        wait_cnt_q[i] <= '0;
      end
    end else begin
      lock_q      <= lock_d;
      lock_chan_q <= lock_chan_d;
      rr_ptr_q    <= rr_ptr_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_llc_req_arb.sv
// +----------------------------------------------------------------------+
// | tb_llc_req_arb: directed vectors for round-robin and fixed arbiters   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_llc_req_arb;

  localparam int NCH = 2;
  localparam int DEPTH = 4;
  localparam int DW = 16;
  localparam int NVEC = 18;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  llc_req_arb_if #(.NCH(NCH), .DEPTH(DEPTH), .DATA_W(DW)) rr_if ();
  llc_req_arb_if #(.NCH(NCH), .DEPTH(DEPTH), .DATA_W(DW)) fp_if ();

  llc_req_arb #(
    .NCH(NCH), .DEPTH(DEPTH), .DATA_W(DW), .PRIO_MODE(0), .STARVE_LIM(16)
  ) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (rr_if.slave)
  );

  llc_req_arb #(
    .NCH(NCH), .DEPTH(DEPTH), .DATA_W(DW), .PRIO_MODE(1), .STARVE_LIM(4)
  ) u_fp (
    .clk (clk),
    .rst (rst),
    .bus (fp_if.slave)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  vld;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        ordy;
    logic        e_valid;
    logic        e_chan;
    logic [15:0] e_data;
    logic [1:0]  e_ready;
    logic [2:0]  e_c0;
    logic [2:0]  e_c1;
  } vec_t;

  vec_t tbl [NVEC];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [1:0] v, input logic [15:0] d0,
                              input logic [15:0] d1, input logic ordy, input logic ev,
                              input logic ec, input logic [15:0] ed, input logic [1:0] er,
                              input logic [2:0] c0, input logic [2:0] c1);
    vec_t t;
    t.rst = r; t.vld = v; t.d0 = d0; t.d1 = d1; t.ordy = ordy;
    t.e_valid = ev; t.e_chan = ec; t.e_data = ed; t.e_ready = er; t.e_c0 = c0; t.e_c1 = c1;
    return t;
  endfunction

  task automatic drv_rr(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1,
                        input logic ordy);
    rr_if.in_valid  = v;
    rr_if.in_data   = {d1, d0};
    rr_if.out_ready = ordy;
  endtask

  task automatic drv_fp(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1,
                        input logic ordy);
    fp_if.in_valid  = v;
    fp_if.in_data   = {d1, d0};
    fp_if.out_ready = ordy;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv_rr(2'b00, 16'h0, 16'h0, 1'b0);
    drv_fp(2'b00, 16'h0, 16'h0, 1'b0);
    adv();
    rst = 1'b0;
  endtask

  initial begin
    // Fill to full, then round-robin drain of three entries per channel.
    tbl[0]  = mk(1, 2'b00, 16'h0,    16'h0,    0, 0, 0, 16'h0,    2'b11, 0, 0);
    tbl[1]  = mk(0, 2'b01, 16'hA001, 16'h0,    0, 0, 0, 16'h0,    2'b11, 0, 0);
    tbl[2]  = mk(0, 2'b01, 16'hA002, 16'h0,    0, 1, 0, 16'hA001, 2'b11, 1, 0);
    tbl[3]  = mk(0, 2'b01, 16'hA003, 16'h0,    0, 1, 0, 16'hA001, 2'b11, 2, 0);
    tbl[4]  = mk(0, 2'b01, 16'hA004, 16'h0,    0, 1, 0, 16'hA001, 2'b11, 3, 0);
    tbl[5]  = mk(0, 2'b01, 16'hA005, 16'h0,    0, 1, 0, 16'hA001, 2'b10, 4, 0);
    tbl[6]  = mk(0, 2'b00, 16'h0,    16'h0,    0, 1, 0, 16'hA001, 2'b10, 4, 0);
    tbl[7]  = mk(1, 2'b00, 16'h0,    16'h0,    0, 0, 0, 16'h0,    2'b11, 0, 0);
    tbl[8]  = mk(0, 2'b11, 16'hA011, 16'hB011, 0, 0, 0, 16'h0,    2'b11, 0, 0);
    tbl[9]  = mk(0, 2'b11, 16'hA012, 16'hB012, 0, 1, 0, 16'hA011, 2'b11, 1, 1);
    tbl[10] = mk(0, 2'b11, 16'hA013, 16'hB013, 0, 1, 0, 16'hA011, 2'b11, 2, 2);
    tbl[11] = mk(0, 2'b00, 16'h0,    16'h0,    1, 1, 0, 16'hA011, 2'b11, 3, 3);
    tbl[12] = mk(0, 2'b00, 16'h0,    16'h0,    1, 1, 1, 16'hB011, 2'b11, 2, 3);
    tbl[13] = mk(0, 2'b00, 16'h0,    16'h0,    1, 1, 0, 16'hA012, 2'b11, 2, 2);
    tbl[14] = mk(0, 2'b00, 16'h0,    16'h0,    1, 1, 1, 16'hB012, 2'b11, 1, 2);
    tbl[15] = mk(0, 2'b00, 16'h0,    16'h0,    1, 1, 0, 16'hA013, 2'b11, 1, 1);
    tbl[16] = mk(0, 2'b00, 16'h0,    16'h0,    1, 1, 1, 16'hB013, 2'b11, 0, 1);
    tbl[17] = mk(0, 2'b00, 16'h0,    16'h0,    1, 0, 0, 16'h0,    2'b11, 0, 0);

    rst = 1'b1;
    drv_rr(2'b00, 16'h0, 16'h0, 1'b0);
    drv_fp(2'b00, 16'h0, 16'h0, 1'b0);
    adv();
    adv();

    for (int i = 0; i < NVEC; i++) begin
      rst = tbl[i].rst;
      drv_rr(tbl[i].vld, tbl[i].d0, tbl[i].d1, tbl[i].ordy);
      #1;
      chk($sformatf("vec%0d out_valid", i), 32'(rr_if.out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d out_chan", i), 32'(rr_if.out_chan), 32'(tbl[i].e_chan));
      chk($sformatf("vec%0d in_ready", i), 32'(rr_if.in_ready), 32'(tbl[i].e_ready));
      chk($sformatf("vec%0d in_count0", i), 32'(rr_if.in_count[2:0]), 32'(tbl[i].e_c0));
      chk($sformatf("vec%0d in_count1", i), 32'(rr_if.in_count[5:3]), 32'(tbl[i].e_c1));
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d out_data", i), 32'(rr_if.out_data), 32'(tbl[i].e_data));
      end
      adv();
    end

    // Grant lock on channel 1 while channel 0 fills.
    do_reset();
    drv_rr(2'b10, 16'h0, 16'hB021, 1'b0); #1;
    chk("lock c0 out_valid", 32'(rr_if.out_valid), 32'd0);
    adv();
    drv_rr(2'b01, 16'hA021, 16'h0, 1'b0); #1;
    chk("lock c1 out_chan", 32'(rr_if.out_chan), 32'd1);
    chk("lock c1 out_data", 32'(rr_if.out_data), 32'hB021);
    adv();
    drv_rr(2'b01, 16'hA022, 16'h0, 1'b0); #1;
    chk("lock c2 out_chan", 32'(rr_if.out_chan), 32'd1);
    chk("lock c2 out_data", 32'(rr_if.out_data), 32'hB021);
    adv();
    drv_rr(2'b01, 16'hA023, 16'h0, 1'b0); #1;
    chk("lock c3 out_chan", 32'(rr_if.out_chan), 32'd1);
    chk("lock c3 out_data", 32'(rr_if.out_data), 32'hB021);
    adv();
    drv_rr(2'b00, 16'h0, 16'h0, 1'b1); #1;
    chk("lock c4 out_chan", 32'(rr_if.out_chan), 32'd1);
    chk("lock c4 out_data", 32'(rr_if.out_data), 32'hB021);
    chk("lock c4 in_count0", 32'(rr_if.in_count[2:0]), 32'd3);
    adv();
    drv_rr(2'b00, 16'h0, 16'h0, 1'b0); #1;
    chk("lock c5 out_chan", 32'(rr_if.out_chan), 32'd0);
    chk("lock c5 out_data", 32'(rr_if.out_data), 32'hA021);
    chk("lock c5 in_count1", 32'(rr_if.in_count[5:3]), 32'd0);

    // Push into empty, same-cycle push and pop, then reset with entries queued.
    do_reset();
    drv_rr(2'b01, 16'hA031, 16'h0, 1'b0); #1;
    chk("simul empty push out_valid", 32'(rr_if.out_valid), 32'd0);
    adv();
    drv_rr(2'b00, 16'h0, 16'h0, 1'b0); #1;
    chk("simul next out_valid", 32'(rr_if.out_valid), 32'd1);
    chk("simul next out_data", 32'(rr_if.out_data), 32'hA031);
    chk("simul next in_count0", 32'(rr_if.in_count[2:0]), 32'd1);
    adv();
    drv_rr(2'b01, 16'hA032, 16'h0, 1'b1); #1;
    chk("simul pushpop out_data", 32'(rr_if.out_data), 32'hA031);
    adv();
    drv_rr(2'b01, 16'hA033, 16'h0, 1'b0); #1;
    chk("simul after in_count0", 32'(rr_if.in_count[2:0]), 32'd1);
    chk("simul after out_data", 32'(rr_if.out_data), 32'hA032);
    adv();
    drv_rr(2'b01, 16'hA034, 16'h0, 1'b0); #1;
    chk("rstmid fill in_count0", 32'(rr_if.in_count[2:0]), 32'd2);
    adv();
    drv_rr(2'b00, 16'h0, 16'h0, 1'b0); #1;
    chk("rstmid queued in_count0", 32'(rr_if.in_count[2:0]), 32'd3);
    rst = 1'b1;
    drv_rr(2'b11, 16'hA035, 16'hB035, 1'b1);
    adv();
    rst = 1'b0;
    drv_rr(2'b00, 16'h0, 16'h0, 1'b0); #1;
    chk("rstmid out_valid", 32'(rr_if.out_valid), 32'd0);
    chk("rstmid in_count", 32'(rr_if.in_count), 32'd0);
    chk("rstmid in_ready", 32'(rr_if.in_ready), 32'd3);
    chk("rstmid out_chan", 32'(rr_if.out_chan), 32'd0);
    adv();
    #1;
    chk("rstmid later out_valid", 32'(rr_if.out_valid), 32'd0);

    // Fixed priority with starvation promotion at wait = 4.
    do_reset();
    drv_fp(2'b01, 16'hA041, 16'h0, 1'b0); #1;
    chk("starve c0 out_valid", 32'(fp_if.out_valid), 32'd0);
    adv();
    drv_fp(2'b11, 16'hA042, 16'hB041, 1'b1); #1;
    chk("starve c1 out_chan", 32'(fp_if.out_chan), 32'd0);
    chk("starve c1 out_data", 32'(fp_if.out_data), 32'hA041);
    adv();
    for (int k = 2; k <= 12; k++) begin
      drv_fp((k == 7) ? 2'b11 : 2'b01, 16'hA040 + 16'(k + 1), 16'hB042, 1'b1); #1;
      chk($sformatf("starve c%0d out_chan", k), 32'(fp_if.out_chan),
          ((k == 6) || (k == 12)) ? 32'd1 : 32'd0);
      if (k == 2) chk("starve c2 out_data", 32'(fp_if.out_data), 32'hA042);
      if (k == 6) chk("starve c6 out_data", 32'(fp_if.out_data), 32'hB041);
      if (k == 7) chk("starve c7 out_data", 32'(fp_if.out_data), 32'hA046);
      if (k == 12) chk("starve c12 out_data", 32'(fp_if.out_data), 32'hB042);
      adv();
    end
    drv_fp(2'b00, 16'h0, 16'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/llc_req_arb.md
LLC_REQ_ARB -- requirements
Module: llc_req_arb

Interface
REQ-001 SHALL have parameter NCH, default 2, number of request input channels (range 2..8).
REQ-002 SHALL have parameter DEPTH, default 4, entries per channel FIFO (power of two, at least 2).
REQ-003 SHALL have parameter DATA_W, default 128, packed request message width.
REQ-004 SHALL have parameter PRIO_MODE, default 0: 0 = round-robin, 1 = fixed priority with anti-starvation.
REQ-005 SHALL have parameter STARVE_LIM, default 16, wait cycles before a channel is promoted (PRIO_MODE=1 only).
REQ-006 Ports SHALL be:
  clk  in  1  clock; one clock domain, all logic on rising edge.
  rst  in  1  reset; synchronous, active-high.
  in_valid  in  NCH  per-channel request valid.
  in_data  in  NCH*DATA_W  per-channel message; channel i occupies bits [i*DATA_W +: DATA_W].
  in_ready  out  NCH  per-channel FIFO not full.
  out_valid  out  1  granted message available.
  out_data  out  DATA_W  head entry of the granted channel.
  out_chan  out  CH_W = max(1, clog2(NCH))  index of the granted channel.
  out_ready  in  1  consumer accepts.
  in_count  out  NCH*(clog2(DEPTH)+1)  per-channel occupancy.

Function
REQ-007 Each channel SHALL buffer requests in its own FIFO; push occurs on in_valid[i] && in_ready[i].
REQ-008 in_ready[i] SHALL equal (count[i] < DEPTH) and SHALL NOT depend combinationally on out_ready; a full FIFO rejects a push even if it pops in the same cycle.
REQ-009 Push and pop on the same channel in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-010 There SHALL be no bypass: data pushed in cycle t is visible on out_data no earlier than t+1; an empty FIFO with a simultaneous push does not pop.
REQ-011 out_valid SHALL be 1 when any FIFO is non-empty; out_data and out_chan SHALL present the granted channel's head entry.
REQ-012 Once out_valid=1 and out_ready=0, the grant SHALL be locked: out_chan and out_data stay stable until the handshake completes.
REQ-013 A pop SHALL occur only on out_valid && out_ready, from channel out_chan only.
REQ-014 Round-robin (PRIO_MODE=0): grant the first non-empty channel at or after rr_ptr in ascending index order with wrap; after a handshake, rr_ptr SHALL become (out_chan+1) mod NCH.
REQ-015 Fixed (PRIO_MODE=1): the lowest-index non-empty channel wins, unless one or more channels have wait[i] >= STARVE_LIM, in which case the lowest-index starved channel wins.
REQ-016 wait[i] SHALL increment each cycle channel i is non-empty and not popped, saturate at STARVE_LIM, and clear to 0 on a pop of channel i; in PRIO_MODE=0 wait counters SHALL hold 0.
REQ-017 Pointer and count arithmetic SHALL wrap modulo DEPTH (pointers) and modulo NCH (rr_ptr) with no overflow past DEPTH.

Reset
REQ-018 While rst=1: all counts, FIFO pointers, wait counters and rr_ptr SHALL be 0, and the grant lock SHALL be cleared.
REQ-019 Reset-time outputs SHALL be out_valid=0, out_chan=0, in_count=0 and in_ready=all ones; out_data is don't-care.
REQ-020 Reset asserted mid-transfer SHALL discard all buffered entries, with no pop or push taking effect in that cycle.

Structure
REQ-021 The PRIO_MODE encoding, clog2-derived width constants and the channel-index typedef SHALL live in a shared package, llc_arb_pkg.
REQ-022 A single sub-module, llc_chan_fifo (parametrised DEPTH/DATA_W, with count output), SHALL be instantiated NCH times.
REQ-023 FIFO storage SHALL be flop-based; the arbiter SHALL contain no latches or combinational loops through out_ready.

Verification
REQ-024 Fill: NCH=2, DEPTH=4, out_ready=0, push 5 entries on channel 0 -> in_ready[0]=0 after the 4th push, in_count[0]=4, 5th push rejected.
REQ-025 Round-robin: both channels hold 3 entries, out_ready=1 constantly -> out_chan sequence 0,1,0,1,0,1, data order preserved per channel.
REQ-026 Lock: out_valid=1 on channel 1, out_ready=0 for 3 cycles while channel 0 fills -> out_chan stays 1 and out_data stable until accepted.
REQ-027 Starvation: PRIO_MODE=1, STARVE_LIM=4, channel 0 continuously refilled and channel 1 holds 1 entry -> channel 1 granted exactly when wait[1] reaches 4, and wait[1] is 0 the next cycle.
REQ-028 Simultaneous events: count=1, push and pop on the same cycle -> count stays 1, next head is the new entry; empty FIFO plus push -> out_valid is 0 in that cycle and 1 the next.
REQ-029 Reset mid-operation: rst=1 for one cycle with 3 entries queued -> next cycle out_valid=0, in_count=0, in_ready all ones.
